scroll_load_sequencer: RTL and testbench

SCROLL_LOAD_SEQUENCER -- requirements
Module: scroll_load_sequencer

---
 rtl/scroll_load_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_scroll_load_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_load_sequencer.sv
// scroll_load_sequencer
//   Sequences loads and count pulses for an external 9-bit up/down loadable
//   scroll counter. That counter acts only on a 0->1 edge of cnt_cen sampled
//   on clk. The CPU stages a 9-bit value with its direction and enable. The
//   committed value is loaded at the next line boundary. After the load,
//   pixel-rate enables outside hblank become single count pulses. shadow_q
//   tracks the value the external counter should hold.
//
// Ports
//   clk         in   system clock, sole clock domain
//   Reset_n     in   asynchronous active-low reset
//   cpu_wr      in   one-clk CPU write strobe
//   cpu_addr    in   0 = staged low byte, 1 = control byte + commit
//   cpu_din     in   [7:0] write data; control: bit0 = P[8], bit1 = dir (1 up),
//                    bit2 = count enable
//   pix_cen     in   pixel-rate enable, one clk wide
//   hblank      in   high = no counting
//   line_start  in   one-clk pulse at line boundary
//   cnt_cen     out  counter clock-enable pulse (one clk high per action)
//   cnt_load_n  out  counter parallel-load, active low
//   cnt_dir     out  counter direction, 1 = up
//   cnt_ent_n   out  counter ENT, active low
//   cnt_enp_n   out  counter ENP, active low
//   cnt_p       out  [8:0] counter parallel-load data
//   shadow_q    out  [8:0] predicted counter value
//   pending     out  committed value waiting for a line boundary
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | out of reset, nothing loaded yet; pixel enables ignored
// LOAD1 | load_n low, cen high: the counter captures cnt_p
// LOAD2 | cen low, load_n still low so the load edge stays clean
// RUN   | counter loaded; pixel enables become count pulses

module scroll_load_sequencer (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       cpu_wr,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       pix_cen,
    input  logic       hblank,
    input  logic       line_start,
    output logic       cnt_cen,
    output logic       cnt_load_n,
    output logic       cnt_dir,
    output logic       cnt_ent_n,
    output logic       cnt_enp_n,
    output logic [8:0] cnt_p,
    output logic [8:0] shadow_q,
    output logic       pending
);

    typedef enum logic [1:0] {IDLE, LOAD1, LOAD2, RUN} state_t;

    state_t     state, state_d;
    logic [7:0] stg_lo;
    logic [8:0] com_val;
    logic       com_dir;
    logic       com_en;
    logic       load_req;
    logic [8:0] drv_p;
    logic       drv_dir;
    logic       run_en;
    logic       pulse;

    logic       commit;
    logic [8:0] com_val_d;
    logic       com_dir_d;
    logic       com_en_d;
    logic       req_eff;
    logic       load_go;
    logic       count_go;
    logic       load_req_d;
    logic       pending_d;

    always_comb begin
        commit     = cpu_wr & cpu_addr;
        com_val_d  = com_val;
        com_dir_d  = com_dir;
        com_en_d   = com_en;
        if (commit) begin
            com_val_d = {cpu_din[0], stg_lo};
            com_dir_d = cpu_din[1];
            com_en_d  = cpu_din[2];
        end

        // A line_start in the same clk counts at once, so the load starts on
        // the next edge without waiting for load_req to register.
        req_eff  = ((state == IDLE) || (state == RUN)) &&
                   (load_req || (line_start && pending));
        // Wait out an active count pulse so cnt_cen always drops between actions.
        load_go  = req_eff && !pulse;
        count_go = (state == RUN) && pix_cen && run_en && !hblank &&
                   !pulse && !load_go;

        state_d    = state;
        load_req_d = load_req;
        case (state)
            IDLE: begin
                load_req_d = req_eff && !load_go;
                if (load_go) state_d = LOAD1;
            end
            LOAD1: begin
                load_req_d = 1'b0;
                state_d    = LOAD2;
            end
            LOAD2: begin
                state_d = RUN;
            end
            RUN: begin
                load_req_d = req_eff && !load_go;
                if (load_go) state_d = LOAD1;
            end
            default: begin
                load_req_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        // A commit landing in the LOAD1 clk is newer than the value being
        // loaded, so it must stay pending.
        pending_d = pending;
        if (commit)
            pending_d = 1'b1;
        else if (state == LOAD1)
            pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stg_lo   <= '0;
            com_val  <= '0;
            com_dir  <= 1'b0;
            com_en   <= 1'b0;
            pending  <= 1'b0;
            load_req <= 1'b0;
            drv_p    <= '0;
            drv_dir  <= 1'b1;
            run_en   <= 1'b0;
            pulse    <= 1'b0;
            shadow_q <= '0;
        end else begin
            if (cpu_wr && !cpu_addr)
                stg_lo <= cpu_din;
            com_val  <= com_val_d;
            com_dir  <= com_dir_d;
            com_en   <= com_en_d;
            pending  <= pending_d;
            load_req <= load_req_d;
            pulse    <= count_go;
            // Capture the load operands on entry so they hold steady through
            // LOAD1/LOAD2, even if the CPU commits again meanwhile.
            if (load_go) begin
                drv_p   <= com_val_d;
                drv_dir <= com_dir_d;
                run_en  <= com_en_d;
            end
            if (state == LOAD1)
                shadow_q <= drv_p;
            else if (count_go)
                shadow_q <= drv_dir ? shadow_q + 9'd1 : shadow_q - 9'd1;
        end
    end

    assign cnt_cen    = (state == LOAD1) || pulse;
    assign cnt_load_n = !((state == LOAD1) || (state == LOAD2));
    assign cnt_ent_n  = !pulse;
    assign cnt_enp_n  = !pulse;
    assign cnt_dir    = drv_dir;
    assign cnt_p      = drv_p;

endmodule

// File: tb/tb_scroll_load_sequencer.sv
module tb_scroll_load_sequencer;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_addr = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       pix_cen = 1'b0;
    logic       hblank = 1'b0;
    logic       line_start = 1'b0;
    logic       cnt_cen, cnt_load_n, cnt_dir, cnt_ent_n, cnt_enp_n, pending;
    logic [8:0] cnt_p, shadow_q;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    scroll_load_sequencer dut (
        .clk(clk), .Reset_n(Reset_n), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .pix_cen(pix_cen), .hblank(hblank),
        .line_start(line_start), .cnt_cen(cnt_cen), .cnt_load_n(cnt_load_n),
        .cnt_dir(cnt_dir), .cnt_ent_n(cnt_ent_n), .cnt_enp_n(cnt_enp_n),
        .cnt_p(cnt_p), .shadow_q(shadow_q), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: where the load is (0 none, 1 = first load clk,
    // 2 = second), whether a count pulse is on the wire, plus CPU-side values.
    int m_phase, m_lo, m_val, m_p, m_shadow;
    bit m_run, m_pulse, m_pending, m_req, m_dir, m_en, m_cdir, m_ren;

    task automatic model_reset();
        m_phase = 0; m_lo = 0; m_val = 0; m_p = 0; m_shadow = 0;
        m_run = 0; m_pulse = 0; m_pending = 0; m_req = 0;
        m_dir = 0; m_en = 0; m_cdir = 1; m_ren = 0;
    endtask

    always @(posedge clk or negedge Reset_n) begin : model
        bit req_now, go, cnt, commit, ndir, nen;
        int nval;
        if (!Reset_n) begin
            model_reset();
        end else begin
            commit  = cpu_wr && cpu_addr;
            nval    = commit ? ({31'd0, cpu_din[0]} * 256 + m_lo) : m_val;
            ndir    = commit ? cpu_din[1] : m_dir;
            nen     = commit ? cpu_din[2] : m_en;
            req_now = (m_phase == 0) && (m_req || (line_start && m_pending));
            go      = req_now && !m_pulse;
            cnt     = m_run && (m_phase == 0) && !go && pix_cen && m_ren &&
                      !hblank && !m_pulse;
            if (cpu_wr && !cpu_addr) m_lo = cpu_din;
            if (go) begin
                m_phase = 1; m_p = nval; m_cdir = ndir; m_ren = nen; m_req = 0;
            end else if (m_phase == 1) begin
                m_phase = 2; m_shadow = m_p; m_req = 0;
            end else if (m_phase == 2) begin
                m_phase = 0; m_run = 1;
            end else begin
                m_req = req_now;
            end
            if (commit) m_pending = 1;
            else if (m_phase == 2) m_pending = 0;
            m_val = nval; m_dir = ndir; m_en = nen;
            m_pulse = cnt;
            if (cnt) m_shadow = m_cdir ? (m_shadow + 1) % 512 : (m_shadow + 511) % 512;
        end
    end

    task automatic cmp(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("m_cen",    int'(cnt_cen),    int'((m_phase == 1) || m_pulse));
            cmp("m_load_n", int'(cnt_load_n), int'(m_phase == 0));
            cmp("m_ent_n",  int'(cnt_ent_n),  int'(!m_pulse));
            cmp("m_enp_n",  int'(cnt_enp_n),  int'(!m_pulse));
            cmp("m_dir",    int'(cnt_dir),    int'(m_cdir));
            cmp("m_p",      int'(cnt_p),      m_p);
            cmp("m_shadow", int'(shadow_q),   m_shadow);
            cmp("m_pending", int'(pending),   int'(m_pending));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input bit a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic load(input logic [7:0] lo, input logic [7:0] ctl);
        wr(1'b0, lo); wr(1'b1, ctl);
        line_start = 1'b1; step(); line_start = 1'b0;
        step(); step();
    endtask

    task automatic chk_reset_vals(input string tag);
        cmp({tag, "_cen"},    int'(cnt_cen), 0);
        cmp({tag, "_load_n"}, int'(cnt_load_n), 1);
        cmp({tag, "_ent_n"},  int'(cnt_ent_n), 1);
        cmp({tag, "_enp_n"},  int'(cnt_enp_n), 1);
        cmp({tag, "_dir"},    int'(cnt_dir), 1);
        cmp({tag, "_p"},      int'(cnt_p), 0);
        cmp({tag, "_shadow"}, int'(shadow_q), 0);
        cmp({tag, "_pending"}, int'(pending), 0);
    endtask

    initial begin
        step(); step();
        cmp_en = 1'b1;
        chk_reset_vals("rst");
        Reset_n = 1'b1;
        step();

        // Basic load of 0x134, up
        wr(1'b0, 8'h34); wr(1'b1, 8'h07);
        cmp("commit_pending", int'(pending), 1);
        line_start = 1'b1; step(); line_start = 1'b0;
        cmp("ld1_cen", int'(cnt_cen), 1);
        cmp("ld1_load_n", int'(cnt_load_n), 0);
        cmp("ld1_p", int'(cnt_p), 'h134);
        cmp("ld1_dir", int'(cnt_dir), 1);
        step();
        cmp("ld2_cen", int'(cnt_cen), 0);
        cmp("ld2_load_n", int'(cnt_load_n), 0);
        step();
        cmp("run_load_n", int'(cnt_load_n), 1);
        cmp("run_pending", int'(pending), 0);
        cmp("run_shadow", int'(shadow_q), 'h134);

        // Up-wrap 0x1FF -> 0x000
        load(8'hFF, 8'h07);
        pix_cen = 1'b1; step(); pix_cen = 1'b0;
        cmp("upwrap_cen", int'(cnt_cen), 1);
        cmp("upwrap_ent_n", int'(cnt_ent_n), 0);
        cmp("upwrap_enp_n", int'(cnt_enp_n), 0);
        cmp("upwrap_shadow", int'(shadow_q), 0);
        step();
        cmp("upwrap_cen_off", int'(cnt_cen), 0);
        cmp("upwrap_ent_off", int'(cnt_ent_n), 1);

        // Down-wrap 0x000 -> 0x1FF
        load(8'h00, 8'h04);
        pix_cen = 1'b1; step(); pix_cen = 1'b0;
        cmp("dnwrap_dir", int'(cnt_dir), 0);
        cmp("dnwrap_shadow", int'(shadow_q), 'h1FF);
        step();

        // Back-to-back pix_cen yields one pulse
        pix_cen = 1'b1; step();
        cmp("b2b_cen1", int'(cnt_cen), 1);
        cmp("b2b_shadow1", int'(shadow_q), 'h1FE);
        step(); pix_cen = 1'b0;
        cmp("b2b_cen2", int'(cnt_cen), 0);
        step();
        cmp("b2b_cen3", int'(cnt_cen), 0);
        cmp("b2b_shadow3", int'(shadow_q), 'h1FE);

        // hblank and en=0 block counting
        hblank = 1'b1; pix_cen = 1'b1; step(); step();
        hblank = 1'b0; pix_cen = 1'b0;
        cmp("hblank_cen", int'(cnt_cen), 0);
        cmp("hblank_shadow", int'(shadow_q), 'h1FE);
        load(8'h55, 8'h03);
        pix_cen = 1'b1; step(); step(); pix_cen = 1'b0;
        cmp("en0_cen", int'(cnt_cen), 0);
        cmp("en0_shadow", int'(shadow_q), 'h155);

        // Last commit wins; commit during LOAD1 stays pending
        wr(1'b0, 8'h10); wr(1'b1, 8'h04);
        wr(1'b0, 8'h20); wr(1'b1, 8'h04);
        line_start = 1'b1; step(); line_start = 1'b0;
        cmp("lastwins_p", int'(cnt_p), 'h020);
        wr(1'b1, 8'h05);
        cmp("ld1commit_pending", int'(pending), 1);
        step();
        cmp("ld1commit_shadow", int'(shadow_q), 'h020);
        cmp("ld1commit_pending2", int'(pending), 1);
        line_start = 1'b1; step(); line_start = 1'b0;
        cmp("reload_cen", int'(cnt_cen), 1);
        cmp("reload_p", int'(cnt_p), 'h120);
        step(); step();
        cmp("reload_shadow", int'(shadow_q), 'h120);
        cmp("reload_pending", int'(pending), 0);

        // Reset during LOAD2 aborts the load
        wr(1'b0, 8'hAB); wr(1'b1, 8'h07);
        line_start = 1'b1; step(); line_start = 1'b0;
        step();
        #2 Reset_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        step(); Reset_n = 1'b1;
        line_start = 1'b1; step(); line_start = 1'b0;
        cmp("postrst_cen", int'(cnt_cen), 0);
        cmp("postrst_load_n", int'(cnt_load_n), 1);
        step();
        cmp("postrst_cen2", int'(cnt_cen), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cpu_wr     = ($urandom_range(0, 9) == 0);
            cpu_addr   = $urandom_range(0, 1);
            cpu_din    = 8'($urandom);
            pix_cen    = ($urandom_range(0, 4) < 2);
            hblank     = ($urandom_range(0, 4) == 0);
            line_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset_n = 1'b0;
                step();
                Reset_n = 1'b1;
            end else begin
                step();
            end
        end
        cpu_wr = 1'b0; pix_cen = 1'b0; line_start = 1'b0; hblank = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
